// File: rtl/projectile_flight.sv
// projectile_flight: consumer side of the throw handshake. Latches launch power on throw_flag,
// steps a gravity ballistic path on a fixed tick and reports the outcome with end_throw/hit.
module projectile_flight #(
    parameter int unsigned TICK_CYCLES = 666667,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned P0_X        = 100,
    parameter int unsigned P1_X        = 700,
    parameter int unsigned START_Y     = 400,
    parameter int unsigned GROUND_Y    = 500,
    parameter int unsigned SCREEN_W    = 800,
    parameter int unsigned TARGET_W    = 48,
    parameter int unsigned TARGET_H    = 48
) (
    input  logic        clk40MHz,
    input  logic        rst,
    input  logic        throw_flag,
    input  logic [4:0]  power,
    input  logic        current_player,
    input  logic [11:0] target_x,
    input  logic [11:0] target_y,
    output logic        end_throw,
    output logic        hit,
    output logic [11:0] proj_x,
    output logic [11:0] proj_y,
    output logic        proj_active
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);
    localparam logic signed [12:0] X_MAX_S  = 13'(SCREEN_W - 1);
    localparam logic [11:0] X_MAX_U        = 12'(SCREEN_W - 1);
    localparam logic signed [13:0] TW_S     = 14'(TARGET_W);
    localparam logic signed [13:0] TH_S     = 14'(TARGET_H);
    localparam logic signed [8:0] GRAV_S    = 9'(GRAVITY);
    localparam logic signed [8:0] VY_MIN    = -9'sd127;

    typedef enum logic [2:0] {StIdle, StLaunch, StFly, StDone, StRelease} state_e;

    state_e state_q, state_d;

    logic              dir_q;
    logic [4:0]        vx_q;
    logic signed [7:0] vy_q;
    logic [11:0]       proj_x_q, proj_y_q;
    logic              active_q;
    logic              hit_r_q;
    logic [CNT_W-1:0]  tick_q;

    logic              tick_last;
    logic signed [12:0] x_n, y_n;
    logic signed [13:0] x_w, y_w, tx_lo, tx_hi, ty_lo, ty_hi;
    logic signed [8:0] vy_dec;
    logic signed [7:0] vy_next;
    logic              in_box, off_left, off_right;
    logic              term_hit, term_ground, term_edge, terminate;
    logic [11:0]       x_clamp, x_store, y_store;

    assign tick_last = (tick_q == TICK_LAST);

    // Candidate position for the next tick and its termination class (hit > ground > edge).
    always_comb begin
        x_n = dir_q ? ($signed({1'b0, proj_x_q}) - $signed({8'b0, vx_q}))
                    : ($signed({1'b0, proj_x_q}) + $signed({8'b0, vx_q}));
        y_n = $signed({1'b0, proj_y_q}) - $signed({{5{vy_q[7]}}, vy_q});

        vy_dec  = $signed({vy_q[7], vy_q}) - GRAV_S;
        vy_next = (vy_dec < VY_MIN) ? -8'sd127 : $signed(vy_dec[7:0]);

        x_w   = $signed({x_n[12], x_n});
        y_w   = $signed({y_n[12], y_n});
        tx_lo = $signed({2'b00, target_x});
        ty_lo = $signed({2'b00, target_y});
        tx_hi = tx_lo + TW_S;
        ty_hi = ty_lo + TH_S;

        in_box    = (x_w >= tx_lo) && (x_w < tx_hi) && (y_w >= ty_lo) && (y_w < ty_hi);
        off_left  = (x_n < 13'sd0);
        off_right = (x_n > X_MAX_S);

        if (off_left) begin
            x_clamp = 12'd0;
        end else if (off_right) begin
            x_clamp = X_MAX_U;
        end else begin
            x_clamp = x_n[11:0];
        end

        term_hit    = in_box;
        term_ground = !in_box && (y_n >= GROUND_S);
        term_edge   = !in_box && !term_ground && (off_left || off_right);
        terminate   = term_hit || term_ground || term_edge;

        x_store = x_n[11:0];
        y_store = y_n[11:0];
        if (term_ground) begin
            x_store = x_clamp;
            y_store = 12'(GROUND_Y);
        end else if (term_edge) begin
            x_store = x_clamp;
        end
    end

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (throw_flag) state_d = StLaunch;
            StLaunch:  state_d = StFly;
            StFly: begin
                if (!throw_flag) begin
                    state_d = StIdle;
                end else if (tick_last && terminate) begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = StRelease;
            // Hold here until the thrower drops the flag so a stale level cannot relaunch.
            StRelease: if (!throw_flag) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        end_throw = (state_q == StDone);
        hit       = (state_q == StDone) && hit_r_q;
    end

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            dir_q    <= 1'b0;
            vx_q     <= 5'd0;
            vy_q     <= 8'sd0;
            proj_x_q <= 12'd0;
            proj_y_q <= 12'd0;
            active_q <= 1'b0;
            hit_r_q  <= 1'b0;
            tick_q   <= '0;
        end else begin
            case (state_q)
                StLaunch: begin
                    dir_q    <= current_player;
                    vx_q     <= power;
                    vy_q     <= $signed({3'b000, power});
                    proj_x_q <= current_player ? 12'(P1_X) : 12'(P0_X);
                    proj_y_q <= 12'(START_Y);
                    active_q <= 1'b1;
                    hit_r_q  <= 1'b0;
                    tick_q   <= '0;
                end
                StFly: begin
                    if (!throw_flag) begin
                        active_q <= 1'b0;
                        tick_q   <= '0;
                    end else if (tick_last) begin
                        tick_q   <= '0;
                        vy_q     <= vy_next;
                        proj_x_q <= x_store;
                        proj_y_q <= y_store;
                        hit_r_q  <= term_hit;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (!throw_flag) begin
                        active_q <= 1'b0;
                        hit_r_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign proj_x      = proj_x_q;
    assign proj_y      = proj_y_q;
    assign proj_active = active_q;

endmodule

// File: doc/projectile_flight.md
Name: projectile_flight

Overview:
- Consumer side of the throw handshake.
- Latches `power` on the rising edge of `throw_flag` and animates the projectile on a fixed tick (gravity ballistic path) from the thrower's position.
- Terminates on target hit, ground or screen edge, then issues a one-cycle `end_throw` back to the throw controller.
- Drives the projectile sprite position for the draw pipeline and reports hit/miss to game logic.

Parameters:
- TICK_CYCLES, 666667, clk40MHz cycles per position update (60 Hz).
- GRAVITY, 1, vertical speed decrement per tick (px/tick²).
- P0_X, 100, launch x for player 0.
- P1_X, 700, launch x for player 1.
- START_Y, 400, launch y for both players.
- GROUND_Y, 500, landing line (y grows downward).
- SCREEN_W, 800, horizontal bound; valid x is 0..SCREEN_W-1.
- TARGET_W, 48, target box width.
- TARGET_H, 48, target box height.

Ports:
- clk40MHz  in  1  system clock
- rst  in  1  synchronous active-high reset
- throw_flag  in  1  high while a throw is in progress (from throw controller)
- power  in  5  launch power, sampled at launch
- current_player  in  1  thrower: 0 throws toward +x, 1 throws toward -x
- target_x  in  12  opponent box left edge
- target_y  in  12  opponent box top edge
- end_throw  out  1  one-cycle pulse: flight finished
- hit  out  1  one-cycle pulse coincident with end_throw when the target was struck
- proj_x  out  12  projectile x
- proj_y  out  12  projectile y
- proj_active  out  1  projectile visible/in flight

Behaviour:
- Reset (rst synchronous, active-high; clock clk40MHz): state IDLE; end_throw=0, hit=0, proj_active=0, proj_x=0, proj_y=0; tick counter=0; vy=0. rst mid-flight aborts immediately with no end_throw.
- States: IDLE, LAUNCH, FLY, DONE, RELEASE.
- IDLE: waits for throw_flag=1 (level).
- LAUNCH (1 cycle):
  - Latch dir=current_player and vx=power.
  - Load vy=+power as signed 8-bit; positive means upward.
  - Load proj_x=P0_X or P1_X and proj_y=START_Y; set proj_active=1.
  - Clear tick counter, then go to FLY.
- FLY:
  - Counter increments each cycle. When it reaches TICK_CYCLES-1 it clears and an update occurs, so the first update is TICK_CYCLES cycles after entering FLY.
  - Update arithmetic uses 13-bit signed intermediates:
    - x_n = proj_x ± vx (+ if dir=0).
    - y_n = proj_y − vy.
    - vy_next = vy − GRAVITY, saturating at −127.
  - Termination is checked on x_n/y_n with priority: hit > ground > edge.
  - Hit: target_x ≤ x_n < target_x+TARGET_W and target_y ≤ y_n < target_y+TARGET_H. Store the position, set hit_r=1, go to DONE.
  - Ground: y_n ≥ GROUND_Y. Store proj_y=GROUND_Y and proj_x=x_n clamped to 0..SCREEN_W-1, go to DONE.
  - Edge: x_n < 0 or x_n > SCREEN_W-1. Clamp x, store y_n, go to DONE.
  - Otherwise store x_n/y_n and stay in FLY.
  - throw_flag=0 in FLY (abnormal): go to IDLE, proj_active=0, no end_throw.
- DONE (1 cycle): end_throw=1 and hit=hit_r; proj_active stays 1; go to RELEASE.
- RELEASE: end_throw=0, hit=0. Wait for throw_flag=0, then proj_active=0, clear hit_r, go to IDLE. This prevents relaunch on the stale flag.
- power=0: vx=0 and vy=0; the projectile drops straight down and lands normally.
- Outputs are registered. end_throw is asserted in the cycle after the terminating update. The thrower deasserts throw_flag on a later cycle.

Test Plan:
Bench parameters: TICK_CYCLES=4, GRAVITY=1, P0_X=100, P1_X=700, START_Y=400, GROUND_Y=500.
1. Reset mid-FLY (after 3 updates) -> next cycle: outputs all 0, state IDLE; a new throw_flag restarts from START_Y.
2. Player 0 miss: power=4, target at (600,100), throw_flag held high.
   - y per tick: 396, 393, 391, 390, 390, 391, …, 495.
   - Tick 20 lands: proj_x=180, proj_y=500.
   - One end_throw pulse with hit=0.
   - Drop throw_flag -> proj_active=0.
3. Player 1 direction: power=4, current_player=1 -> tick 1 proj_x=696, proj_y=396; landing proj_x=620.
4. Hit: power=4, player 0, target at (110,380) -> tick 3 (x=112, y=391) inside box; end_throw=1 and hit=1 in the same cycle; proj_x=112, proj_y=391.
5. Edge and saturation:
   - power=31, player 1, P1_X=40 -> tick 2 x_n=−22; proj_x clamped to 0; end_throw with hit=0.
   - power=0 -> straight drop; proj_x remains P0_X until landing at 500.
6. Handshake:
   - Hold throw_flag high 10 cycles after end_throw -> no relaunch, single end_throw pulse, state RELEASE.
   - Deassert throw_flag mid-FLY -> proj_active=0, no end_throw.
